alu_issue_sequencer: RTL and testbench

Initiator-side controller for the 16-bit ALU datapath. It accepts a decoded instruction (opcode, funct, two operands) over a valid/ready request channel and translates it to the 3-bit ALU control code. It drives the ALU operand and control lines, waits a programmable settle time, captures result and flags, and returns them on a valid/ready response channel with branch-taken and illegal-op indications. It sits between the instruction decode stage and the ALU datapath.

---
 rtl/alu_issue_sequencer_if.sv | 51 +++++
 rtl/alu_issue_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_sequencer_if.sv
`default_nettype none
// ============================================================================
// alu_issue_sequencer_if : request, ALU-issue and response signals of the
// ALU issue sequencer. Revision 1.0
// ============================================================================
interface alu_issue_sequencer_if #(
  parameter int WIDTH = 16
) ();
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opcode;
  logic [2:0]       req_funct;
  logic [WIDTH-1:0] req_op1;
  logic [WIDTH-1:0] req_op2;

  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_carry;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_taken;
  logic             rsp_err;

  // Sequencer side
  modport master (
    input  req_valid, req_opcode, req_funct, req_op1, req_op2,
    input  alu_res, alu_zero, alu_carry,
    input  rsp_ready,
    output req_ready,
    output alu_ctrl, alu_op1, alu_op2,
    output rsp_valid, rsp_res, rsp_zero, rsp_carry, rsp_taken, rsp_err
  );

  // Decode stage / ALU / response consumer side
  modport slave (
    output req_valid, req_opcode, req_funct, req_op1, req_op2,
    output alu_res, alu_zero, alu_carry,
    output rsp_ready,
    input  req_ready,
    input  alu_ctrl, alu_op1, alu_op2,
    input  rsp_valid, rsp_res, rsp_zero, rsp_carry, rsp_taken, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_sequencer.sv
`default_nettype none
// ============================================================================
// alu_issue_sequencer : decodes an instruction, issues it to the ALU, waits
// EXEC_CYCLES (1..15), returns result and flags on a valid/ready channel.
// Revision 1.0
// ============================================================================
module alu_issue_sequencer #(
  parameter int WIDTH       = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_op_rtype   = 4'b0000;
  localparam logic [3:0] c_op_addi    = 4'b0001;
  localparam logic [3:0] c_op_lw      = 4'b0010;
  localparam logic [3:0] c_op_sw      = 4'b0011;
  localparam logic [3:0] c_op_beq     = 4'b0100;
  localparam logic [3:0] c_op_bne     = 4'b0101;
  localparam logic [2:0] c_ctrl_add   = 3'b000;
  localparam logic [2:0] c_ctrl_sub   = 3'b001;
  localparam logic [2:0] c_funct_last = 3'b100;
  localparam logic [3:0] c_cnt_load   = 4'(EXEC_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       r_opcode;
  logic [2:0]       r_alu_ctrl;
  logic [WIDTH-1:0] r_alu_op1;
  logic [WIDTH-1:0] r_alu_op2;
  logic [WIDTH-1:0] r_rsp_res;
  logic             r_rsp_zero;
  logic             r_rsp_carry;
  logic             r_rsp_taken;
  logic             r_rsp_err;

  logic [2:0]       w_dec_ctrl;
  logic             w_dec_legal;
  logic             w_req_ready;
  logic             w_rsp_valid;
  logic             w_issue;
  logic             w_reject;
  logic             w_capture;

  // R-type funct codes 0..4 map one-to-one onto ALU control codes
  always_comb begin
    w_dec_ctrl  = c_ctrl_add;
    w_dec_legal = 1'b0;
    case (bus.req_opcode)
      c_op_rtype: begin
        if (bus.req_funct <= c_funct_last) begin
          w_dec_ctrl  = bus.req_funct;
          w_dec_legal = 1'b1;
        end
      end
      c_op_addi, c_op_lw, c_op_sw: begin
        w_dec_ctrl  = c_ctrl_add;
        w_dec_legal = 1'b1;
      end
      c_op_beq, c_op_bne: begin
        w_dec_ctrl  = c_ctrl_sub;
        w_dec_legal = 1'b1;
      end
      default: begin
        w_dec_ctrl  = c_ctrl_add;
        w_dec_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_issue      = 1'b0;
    w_reject     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_dec_legal) begin
            w_issue      = 1'b1;
            w_state_next = S_EXEC;
          end else begin
            w_reject     = 1'b1;
            w_state_next = S_DONE;
          end
        end
      end
      S_EXEC: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ALU lines only move on a legal issue so the ALU output stays quiet otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_ctrl <= c_ctrl_add;
      r_alu_op1  <= '0;
      r_alu_op2  <= '0;
      r_cnt      <= 4'd0;
      r_opcode   <= 4'd0;
    end else begin
      if (w_issue) begin
        r_alu_ctrl <= w_dec_ctrl;
        r_alu_op1  <= bus.req_op1;
        r_alu_op2  <= bus.req_op2;
        r_cnt      <= c_cnt_load;
      end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_issue || w_reject) begin
        r_opcode <= bus.req_opcode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_res   <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
      r_rsp_taken <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (w_capture) begin
      r_rsp_res   <= bus.alu_res;
      r_rsp_zero  <= bus.alu_zero;
      // Carry is meaningless for logic/compare codes
      r_rsp_carry <= (r_alu_ctrl == c_ctrl_add || r_alu_ctrl == c_ctrl_sub) ? bus.alu_carry : 1'b0;
      r_rsp_taken <= (r_opcode == c_op_beq) ? bus.alu_zero :
                     (r_opcode == c_op_bne) ? ~bus.alu_zero : 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (w_reject) begin
      r_rsp_res   <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
      r_rsp_taken <= 1'b0;
      r_rsp_err   <= 1'b1;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.alu_op1   = r_alu_op1;
  assign bus.alu_op2   = r_alu_op2;
  assign bus.rsp_res   = r_rsp_res;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.rsp_taken = r_rsp_taken;
  assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_sequencer : randomized and directed checks of the sequencer
// against an instruction-level reference model. Revision 1.0
// ============================================================================
module tb_alu_issue_sequencer;
  localparam int W   = 16;
  localparam int EC1 = 1;
  localparam int EC3 = 3;

  typedef struct packed {
    logic         legal;
    logic [2:0]   ctrl;
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         taken;
    logic         err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [2:0]   last_ctrl = 3'd0;
  logic [W-1:0] last_op1  = '0;
  logic [W-1:0] last_op2  = '0;

  always #5 clk = ~clk;

  alu_issue_sequencer_if #(.WIDTH(W)) a ();
  alu_issue_sequencer_if #(.WIDTH(W)) b ();

  alu_issue_sequencer #(.WIDTH(W), .EXEC_CYCLES(EC1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(a.master));
  alu_issue_sequencer #(.WIDTH(W), .EXEC_CYCLES(EC3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b.master));

  // ALU datapath stand-in; carry is deliberately 1 for non-arithmetic codes
  function automatic logic [W+1:0] alu_fn(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         cy;
    s = '0; r = '0; cy = 1'b1;
    case (c)
      3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[W-1:0]; cy = s[W]; end
      3'd1: begin s = {1'b0, x} - {1'b0, y}; r = s[W-1:0]; cy = s[W]; end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: r = '0;
    endcase
    return {cy, (r == '0), r};
  endfunction

  always_comb {a.alu_carry, a.alu_zero, a.alu_res} = alu_fn(a.alu_ctrl, a.alu_op1, a.alu_op2);
  always_comb {b.alu_carry, b.alu_zero, b.alu_res} = alu_fn(b.alu_ctrl, b.alu_op1, b.alu_op2);

  // Instruction-level expectation of the response
  function automatic exp_t model(input logic [3:0] opc, input logic [2:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] wide;
    e = '0; wide = '0;
    if (opc == 4'd0 && fn <= 3'd4) begin e.legal = 1'b1; e.ctrl = fn; end
    else if (opc >= 4'd1 && opc <= 4'd3) begin e.legal = 1'b1; e.ctrl = 3'd0; end
    else if (opc == 4'd4 || opc == 4'd5) begin e.legal = 1'b1; e.ctrl = 3'd1; end
    if (!e.legal) begin
      e.err = 1'b1;
      return e;
    end
    case (e.ctrl)
      3'd0: begin wide = {1'b0, x} + {1'b0, y}; e.res = wide[W-1:0]; e.carry = wide[W]; end
      3'd1: begin wide = {1'b0, x} - {1'b0, y}; e.res = wide[W-1:0]; e.carry = wide[W]; end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      default: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
    endcase
    e.zero  = (e.res == '0);
    e.taken = (opc == 4'd4) ? e.zero : (opc == 4'd5) ? ~e.zero : 1'b0;
    return e;
  endfunction

  task automatic run_op(input logic [3:0] opc, input logic [2:0] fn, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    exp_t e;
    int   lat;
    logic [2*W+2:0] want_alu;
    e = model(opc, fn, x, y);
    @(negedge clk);
    n_checks++;
    if (a.req_ready !== 1'b1) $display("FAIL %s req_ready_idle: got %b want 1", tag, a.req_ready);
    else n_pass++;
    a.req_valid = 1'b1; a.req_opcode = opc; a.req_funct = fn; a.req_op1 = x; a.req_op2 = y;
    @(negedge clk);
    a.req_valid = 1'b0;
    a.req_opcode = 4'($urandom); a.req_funct = 3'($urandom); a.req_op1 = W'($urandom); a.req_op2 = W'($urandom);
    want_alu = e.legal ? {e.ctrl, x, y} : {last_ctrl, last_op1, last_op2};
    n_checks++;
    if ({a.alu_ctrl, a.alu_op1, a.alu_op2} !== want_alu)
      $display("FAIL %s alu_lines: got %h want %h", tag, {a.alu_ctrl, a.alu_op1, a.alu_op2}, want_alu);
    else n_pass++;
    if (e.legal) begin last_ctrl = e.ctrl; last_op1 = x; last_op2 = y; end
    lat = 0;
    while (a.rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== (e.legal ? EC1 : 0)) $display("FAIL %s latency: got %0d want %0d", tag, lat, e.legal ? EC1 : 0);
    else n_pass++;
    n_checks++;
    if ({a.rsp_res, a.rsp_zero, a.rsp_carry, a.rsp_taken, a.rsp_err} !== {e.res, e.zero, e.carry, e.taken, e.err})
      $display("FAIL %s rsp: got res=%h z=%b c=%b t=%b e=%b want res=%h z=%b c=%b t=%b e=%b", tag,
               a.rsp_res, a.rsp_zero, a.rsp_carry, a.rsp_taken, a.rsp_err, e.res, e.zero, e.carry, e.taken, e.err);
    else n_pass++;
    a.rsp_ready = 1'b1;
    @(negedge clk);
    a.rsp_ready = 1'b0;
    n_checks++;
    if (a.rsp_valid !== 1'b0 || a.req_ready !== 1'b1)
      $display("FAIL %s handshake: got valid=%b ready=%b want valid=0 ready=1", tag, a.rsp_valid, a.req_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    a.req_valid = 0; a.req_opcode = 0; a.req_funct = 0; a.req_op1 = 0; a.req_op2 = 0; a.rsp_ready = 0;
    b.req_valid = 0; b.req_opcode = 0; b.req_funct = 0; b.req_op1 = 0; b.req_op2 = 0; b.rsp_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a.rsp_valid, a.rsp_res, a.rsp_zero, a.rsp_carry, a.rsp_taken, a.rsp_err, a.alu_ctrl, a.alu_op1, a.alu_op2} !== '0)
      $display("FAIL reset_outputs: got valid=%b res=%h ctrl=%h op1=%h op2=%h want all 0",
               a.rsp_valid, a.rsp_res, a.alu_ctrl, a.alu_op1, a.alu_op2);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a.req_ready !== 1'b1 || a.rsp_valid !== 1'b0 || b.req_ready !== 1'b1)
      $display("FAIL reset_release: got req_ready=%b rsp_valid=%b want 1/0", a.req_ready, a.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_arith();
    run_op(4'h0, 3'd0, 16'h7FFF, 16'h0001, "add_ovf");
    run_op(4'h0, 3'd1, 16'h0003, 16'h0005, "sub_borrow");
    run_op(4'h0, 3'd0, 16'hFFFF, 16'h0001, "add_wrap");
    run_op(4'h0, 3'd2, 16'h00F0, 16'h0F00, "and_zero");
    run_op(4'h0, 3'd3, 16'h00F0, 16'h0F00, "or");
    run_op(4'h0, 3'd4, 16'hFFFE, 16'h0003, "slt_neg");
    run_op(4'h1, 3'd5, 16'h1000, 16'hFFFF, "addi");
    run_op(4'h2, 3'd7, 16'h0100, 16'h0020, "lw");
    run_op(4'h3, 3'd0, 16'h0200, 16'h0004, "sw");
  endtask

  task automatic test_branch();
    run_op(4'h4, 3'd0, 16'h1234, 16'h1234, "beq_eq");
    run_op(4'h5, 3'd0, 16'h1234, 16'h1234, "bne_eq");
    run_op(4'h4, 3'd0, 16'h1234, 16'h4321, "beq_ne");
    run_op(4'h5, 3'd0, 16'h1234, 16'h4321, "bne_ne");
  endtask

  task automatic test_illegal();
    run_op(4'h0, 3'd3, 16'h5A5A, 16'h0F0F, "pre_legal");
    run_op(4'h7, 3'd0, 16'h1111, 16'h2222, "illegal_op7");
    run_op(4'h0, 3'd6, 16'h3333, 16'h4444, "illegal_funct6");
    run_op(4'hF, 3'd2, 16'h5555, 16'h6666, "illegal_opF");
  endtask

  task automatic test_backpressure();
    exp_t         e;
    int           lat;
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = 16'h0010; y = 16'h0003;
    e = model(4'h0, 3'd1, x, y);
    @(negedge clk);
    a.req_valid = 1'b1; a.req_opcode = 4'h0; a.req_funct = 3'd1; a.req_op1 = x; a.req_op2 = y;
    @(negedge clk);
    a.req_opcode = 4'h1; a.req_op1 = 16'hAAAA; a.req_op2 = 16'h5555;
    lat = 0;
    while (a.rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({a.rsp_valid, a.req_ready, a.rsp_res, a.rsp_zero, a.rsp_carry, a.rsp_taken, a.rsp_err} !==
          {1'b1, 1'b0, e.res, e.zero, e.carry, e.taken, e.err})
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b res=%h c=%b want valid=1 ready=0 res=%h c=%b",
                 i, a.rsp_valid, a.req_ready, a.rsp_res, a.rsp_carry, e.res, e.carry);
      else n_pass++;
      @(negedge clk);
    end
    a.req_valid = 1'b0; a.rsp_ready = 1'b1;
    @(negedge clk);
    a.rsp_ready = 1'b0;
    n_checks++;
    if (a.rsp_valid !== 1'b0 || a.req_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b ready=%b want 0/1", a.rsp_valid, a.req_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (a.rsp_valid !== 1'b0 || a.req_ready !== 1'b1 || a.alu_op1 !== x)
      $display("FAIL bp_ignored: got valid=%b ready=%b op1=%h want 0/1/%h", a.rsp_valid, a.req_ready, a.alu_op1, x);
    else n_pass++;
    last_ctrl = e.ctrl; last_op1 = x; last_op2 = y;
  endtask

  task automatic test_back_to_back();
    exp_t         e;
    int           acc[$];
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = W'($urandom); y = W'($urandom);
    e = model(4'h0, 3'd0, x, y);
    @(negedge clk);
    a.req_valid = 1'b1; a.req_opcode = 4'h0; a.req_funct = 3'd0; a.req_op1 = x; a.req_op2 = y;
    a.rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (a.req_ready === 1'b1) acc.push_back(c);
      if (a.rsp_valid === 1'b1) begin
        n_checks++;
        if ({a.rsp_res, a.rsp_carry, a.rsp_err} !== {e.res, e.carry, e.err})
          $display("FAIL b2b_rsp: got res=%h c=%b e=%b want res=%h c=%b e=%b",
                   a.rsp_res, a.rsp_carry, a.rsp_err, e.res, e.carry, e.err);
        else n_pass++;
      end
      @(negedge clk);
    end
    a.req_valid = 1'b0;
    n_checks++;
    if (acc.size() !== 5) $display("FAIL b2b_count: got %0d accepts want 5", acc.size());
    else n_pass++;
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] !== EC1 + 2)
        $display("FAIL b2b_interval: got %0d want %0d", acc[i] - acc[i-1], EC1 + 2);
      else n_pass++;
    end
    repeat (EC1 + 3) @(negedge clk);
    a.rsp_ready = 1'b0;
    last_ctrl = e.ctrl; last_op1 = x; last_op2 = y;
  endtask

  task automatic test_random();
    logic [3:0]   opc;
    logic [2:0]   fn;
    logic [W-1:0] v[2];
    for (int i = 0; i < 40; i++) begin
      opc = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
      fn  = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0: v[k] = '0;
          1: v[k] = '1;
          2: v[k] = 16'h8000;
          3: v[k] = 16'h7FFF;
          default: v[k] = W'($urandom);
        endcase
      end
      if ($urandom_range(0, 3) == 0) v[1] = v[0];
      run_op(opc, fn, v[0], v[1], "rand");
    end
  endtask

  task automatic test_exec3();
    exp_t e;
    int   lat;
    e = model(4'h0, 3'd4, 16'h0002, 16'h0009);
    @(negedge clk);
    b.req_valid = 1'b1; b.req_opcode = 4'h0; b.req_funct = 3'd4; b.req_op1 = 16'h0002; b.req_op2 = 16'h0009;
    @(negedge clk);
    b.req_valid = 1'b0;
    n_checks++;
    if ({b.alu_ctrl, b.alu_op1, b.alu_op2} !== {3'd4, 16'h0002, 16'h0009})
      $display("FAIL ec3_alu_lines: got %h/%h/%h want 4/0002/0009", b.alu_ctrl, b.alu_op1, b.alu_op2);
    else n_pass++;
    lat = 0;
    while (b.rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== EC3) $display("FAIL ec3_latency: got %0d want %0d", lat, EC3);
    else n_pass++;
    n_checks++;
    if ({b.rsp_res, b.rsp_zero, b.rsp_carry, b.rsp_taken, b.rsp_err} !== {e.res, e.zero, e.carry, e.taken, e.err})
      $display("FAIL ec3_slt_rsp: got res=%h z=%b c=%b t=%b e=%b want res=%h z=%b c=%b t=%b e=%b",
               b.rsp_res, b.rsp_zero, b.rsp_carry, b.rsp_taken, b.rsp_err, e.res, e.zero, e.carry, e.taken, e.err);
    else n_pass++;
    b.rsp_ready = 1'b1;
    @(negedge clk);
    b.rsp_ready = 1'b0;
    // Reset in the middle of EXEC discards the op
    b.req_valid = 1'b1; b.req_opcode = 4'h0; b.req_funct = 3'd0; b.req_op1 = 16'h1111; b.req_op2 = 16'h2222;
    @(negedge clk);
    b.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b.rsp_valid, b.rsp_res, b.rsp_zero, b.rsp_carry, b.rsp_taken, b.rsp_err, b.alu_ctrl, b.alu_op1, b.alu_op2} !== '0)
      $display("FAIL ec3_reset_mid_exec: got valid=%b res=%h ctrl=%h op1=%h op2=%h want all 0",
               b.rsp_valid, b.rsp_res, b.alu_ctrl, b.alu_op1, b.alu_op2);
    else n_pass++;
    last_ctrl = 3'd0; last_op1 = '0; last_op2 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      if (b.rsp_valid === 1'b1) lat++;
      @(negedge clk);
    end
    n_checks++;
    if (lat !== 0 || b.req_ready !== 1'b1)
      $display("FAIL ec3_no_rsp_after_reset: got %0d valid cycles ready=%b want 0 and 1", lat, b.req_ready);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_branch();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_exec3();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
